pl_hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage RISC-V core.
- Drives the hold (en) and clear (clr) inputs of every pipeline register, including the memory→writeback register. Produces EX-stage forwarding selects.
- Owns a data-memory wait FSM that freezes the pipe while a variable-latency data memory completes.
- Consumer side of the en/clr pipeline-register interface: decides when registers hold, load, or bubble.

---
 rtl/pl_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pl_hazard_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pl_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pl_hazard_ctrl
// Purpose  : Hazard/stall controller for the 5-stage RISC-V pipeline.
//            Generates EX forwarding selects, load-use stalls, branch flushes
//            and a data-memory wait FSM with timeout and sticky error flag.
// Options  : HAZ_PERF_CNT_EN - when defined, StallCount counts StallF cycles
//            (saturating); otherwise StallCount is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pl_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic [1:0]  ResultSrcE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemTimeout,
    output logic        MemErr,
    output logic [31:0] StallCount
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Last WAIT cycle index; reaching it without ready abandons the access.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             mem_wait;
    logic             timeout;
    logic             lw_stall;

    // Forwarding: memory stage wins over writeback, x0 never forwarded.
    assign ForwardAE = (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) ? 2'b10 :
                       (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ? 2'b01 : 2'b00;
    assign ForwardBE = (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) ? 2'b10 :
                       (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ? 2'b01 : 2'b00;

    // Load in EX whose destination is read by the instruction in decode.
    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // A memory wait freezes E and the branch, so it overrides their flushes.
    assign StallM     = mem_wait;
    assign StallE     = mem_wait;
    assign StallF     = mem_wait | lw_stall;
    assign StallD     = mem_wait | lw_stall;
    assign FlushE     = !mem_wait & (lw_stall | PCSrcE);
    assign FlushD     = !mem_wait & PCSrcE;
    assign FlushW     = mem_wait;
    assign MemTimeout = timeout;

    // Wait FSM next state, wait counter and the combinational memWait term.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_wait   = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    mem_wait   = 1'b1;
                    state_next = S_WAIT;
                    cnt_next   = '0;
                end
            end
            S_WAIT: begin
                mem_wait = !MemReadyM && (cnt < CNT_LAST);
                timeout  = !MemReadyM && (cnt >= CNT_LAST);
                if (MemReadyM || timeout || !MemReqM) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and sticky error registers; reset drops everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            MemErr <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (timeout) begin
                MemErr <= 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles in which fetch is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (StallF && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pl_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pl_hazard_ctrl
// Purpose  : Directed self-checking bench for pl_hazard_ctrl (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pl_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic [1:0]  ResultSrcE = '0;
    logic        RegWriteM = 1'b0, RegWriteW = 1'b0, PCSrcE = 1'b0;
    logic        MemReqM = 1'b0, MemReadyM = 1'b0;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic        MemTimeout, MemErr;
    logic [31:0] StallCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pl_hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .MemErr(MemErr), .StallCount(StallCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemTimeout}
    task automatic chk_ctl(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout},
            {24'd0, exp});
    endtask

    // New inputs are applied 1 time unit after the rising edge; checks run 2 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE = '0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    logic [31:0] exp_cnt4, exp_cnt8;

    initial begin
`ifdef HAZ_PERF_CNT_EN
        exp_cnt4 = 32'd4;
        exp_cnt8 = 32'd8;
`else
        exp_cnt4 = 32'd0;
        exp_cnt8 = 32'd0;
`endif
        // Reset state
        next_cycle(); reset = 1'b0; #2;
        chk_ctl("reset_ctl", 8'b0000_0000);
        chk("reset_fwdA", {30'd0, ForwardAE}, 32'd0);
        chk("reset_fwdB", {30'd0, ForwardBE}, 32'd0);
        chk("reset_err", {31'd0, MemErr}, 32'd0);
        chk("reset_cnt", StallCount, 32'd0);

        // Forwarding priority
        next_cycle();
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 5; #2;
        chk("fwdA_mem", {30'd0, ForwardAE}, 32'd2);
        chk("fwdB_mem", {30'd0, ForwardBE}, 32'd2);
        next_cycle(); RdM = 0; #2;
        chk("fwdA_wb", {30'd0, ForwardAE}, 32'd1);
        chk("fwdB_wb", {30'd0, ForwardBE}, 32'd1);
        next_cycle(); RdW = 0; #2;
        chk("fwdA_none", {30'd0, ForwardAE}, 32'd0);
        next_cycle(); RdW = 3; Rs2E = 3; RegWriteW = 0; #2;
        chk("fwdB_nowrite", {30'd0, ForwardBE}, 32'd0);

        // Load-use: exactly one stall cycle
        next_cycle(); clear_inputs(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #2;
        chk_ctl("lw_stall", 8'b1100_0100);
        next_cycle(); clear_inputs(); #2;
        chk_ctl("lw_release", 8'b0000_0000);
        next_cycle(); ResultSrcE = 2'b01; RdE = 0; Rs2D = 0; #2;
        chk_ctl("lw_x0", 8'b0000_0000);

        // Branch flush
        next_cycle(); clear_inputs(); PCSrcE = 1; #2;
        chk_ctl("branch", 8'b0000_1100);

        // Memory wait: ready low 3 cycles (branch pending is overridden)
        next_cycle(); MemReqM = 1; MemReadyM = 0; #2;
        chk_ctl("wait_c1", 8'b1111_0010);
        next_cycle(); PCSrcE = 0; #2;
        chk_ctl("wait_c2", 8'b1111_0010);
        next_cycle(); #2;
        chk_ctl("wait_c3", 8'b1111_0010);
        next_cycle(); MemReadyM = 1; #2;
        chk_ctl("wait_ready", 8'b0000_0000);
        next_cycle(); MemReqM = 0; MemReadyM = 0; #2;
        chk_ctl("wait_idle", 8'b0000_0000);
        chk("cnt_after_wait", StallCount, exp_cnt4);

        // Zero-wait access: no stall, FSM stays IDLE
        next_cycle(); MemReqM = 1; MemReadyM = 1; #2;
        chk_ctl("zero_wait1", 8'b0000_0000);
        next_cycle(); #2;
        chk_ctl("zero_wait2", 8'b0000_0000);

        // Timeout: 1 IDLE + 3 WAIT stall cycles, then abandon
        next_cycle(); MemReadyM = 0; #2;
        chk_ctl("to_c1", 8'b1111_0010);
        next_cycle(); #2;
        chk_ctl("to_c2", 8'b1111_0010);
        next_cycle(); #2;
        chk_ctl("to_c3", 8'b1111_0010);
        next_cycle(); #2;
        chk_ctl("to_c4", 8'b1111_0010);
        next_cycle(); #2;
        chk_ctl("to_pulse", 8'b0000_0001);
        chk("to_err_before", {31'd0, MemErr}, 32'd0);
        next_cycle(); MemReqM = 0; #2;
        chk_ctl("to_after", 8'b0000_0000);
        chk("to_err_sticky", {31'd0, MemErr}, 32'd1);
        chk("cnt_after_to", StallCount, exp_cnt8);
        next_cycle(); #2;
        chk("to_err_hold", {31'd0, MemErr}, 32'd1);

        // Reset in the middle of WAIT
        next_cycle(); MemReqM = 1; MemReadyM = 0; #2;
        chk_ctl("rst_wait_c1", 8'b1111_0010);
        next_cycle(); #2;
        chk_ctl("rst_wait_c2", 8'b1111_0010);
        #1; reset = 1'b1; MemReqM = 0; #2;
        chk_ctl("rst_async_ctl", 8'b0000_0000);
        chk("rst_async_err", {31'd0, MemErr}, 32'd0);
        chk("rst_async_cnt", StallCount, 32'd0);
        next_cycle(); reset = 1'b0; MemReqM = 1; MemReadyM = 0; #2;
        chk_ctl("post_rst_idle", 8'b1111_0010);
        next_cycle(); MemReadyM = 1; #2;
        chk_ctl("post_rst_rel", 8'b0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
